// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline control types: sequencer state encoding and per-stage
// write/flush/bubble control words.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN           = 2'd0,
        ST_LU_HOLD       = 2'd1,
        ST_MEM_FREEZE    = 2'd2,
        ST_REDIRECT_PEND = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_write;
    } stage_ctrl_t;

    // Bubble value loaded into ID/EX: all control bits cleared
    localparam int unsigned ID_EX_CTRL_W = 8;
    localparam logic [ID_EX_CTRL_W-1:0] ID_EX_NOP_CTRL = '0;

    localparam stage_ctrl_t CTRL_FREEZE = '0;
    localparam stage_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam stage_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam stage_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/memory request inputs and per-stage control outputs of the
// stall sequencer, plus its debug counters.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic             load_use_stall;
    logic             ex_redirect;
    logic             imem_busy;
    logic             dmem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic             mem_timeout;

    modport master (
        output load_use_stall, ex_redirect, imem_busy, dmem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
        input  ex_mem_write, mem_wb_write,
        input  stall_cycles, flush_count, mem_timeout
    );

    modport slave (
        input  load_use_stall, ex_redirect, imem_busy, dmem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
        output ex_mem_write, mem_wb_write,
        output stall_cycles, flush_count, mem_timeout
    );
endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en && !(&r_q)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/freeze/flush sequencer with perf counters and a
// memory-wait watchdog.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1024,
    parameter int WDOG_W      = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_stall_controller_if.slave   bus
);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

    state_t            r_state;
    state_t            w_state_nxt;
    stage_ctrl_t       w_ctrl;
    logic              w_flush_inc;
    logic              w_stall_inc;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout;
    logic              w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_ctrl      = CTRL_FREEZE;
        w_flush_inc = 1'b0;
        w_state_nxt = ST_RUN;
        if (reset) begin
            w_ctrl = CTRL_FREEZE;
        end else if (bus.dmem_busy) begin
            // A redirect arriving during a freeze must survive until exit
            if (bus.ex_redirect || r_state == ST_REDIRECT_PEND) begin
                w_state_nxt = ST_REDIRECT_PEND;
            end else begin
                w_state_nxt = ST_MEM_FREEZE;
            end
        end else if (bus.ex_redirect || r_state == ST_REDIRECT_PEND) begin
            w_ctrl      = CTRL_FLUSH;
            w_flush_inc = 1'b1;
        end else if (bus.load_use_stall && r_state != ST_LU_HOLD) begin
            w_ctrl      = CTRL_STALL;
            w_state_nxt = ST_LU_HOLD;
        end else if (bus.imem_busy) begin
            w_ctrl = CTRL_STALL;
        end else begin
            w_ctrl = CTRL_RUN;
        end
    end

    assign w_stall_inc = !w_ctrl.pc_write && !reset;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_stall_inc),
        .o_q   (bus.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_flush_inc),
        .o_q   (bus.flush_count)
    );

    assign w_busy = bus.dmem_busy || bus.imem_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_busy) begin
                r_wdog <= '0;
            end else if (r_wdog != WDOG_MAX) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
            if (w_busy && r_wdog == WDOG_MAX - WDOG_W'(1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.pc_write     = w_ctrl.pc_write;
    assign bus.if_id_write  = w_ctrl.if_id_write;
    assign bus.if_id_flush  = w_ctrl.if_id_flush;
    assign bus.id_ex_bubble = w_ctrl.id_ex_bubble;
    assign bus.ex_mem_write = w_ctrl.ex_mem_write;
    assign bus.mem_wb_write = w_ctrl.mem_wb_write;
    assign bus.mem_timeout  = r_timeout;
endmodule
